// File: rtl/sevseg_pkg.sv
// Shared constants for the 8-digit seven-segment scan controller:
// digit count, blank patterns and the active-low hex segment table.
package sevseg_pkg;

  localparam int NUM_DIGITS = 8;

  // All segments off (active-low) and all anodes off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sevseg_scan_ctrl_hex7seg_dec.sv
// Combinational nibble-to-segment decoder (active-low {g..a}).
module hex7seg_dec
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; every nibble value has an entry.
  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Handshake: a transfer happens in any cycle where upd_valid && upd_ready;
// the source must hold upd_valid and its data stable until that cycle.
// Accepted contents wait in a pending register and become active only at
// the frame boundary (last tick of digit 7), so a frame is never mixed.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_value,
  input  logic [7:0]  upd_en_mask,
  input  logic [7:0]  upd_dp_mask,
  input  logic        upd_lzb,
  output logic [6:0]  disp,
  output logic        dp,
  output logic [7:0]  en,
  output logic        frame_start
);

  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_TICKS);
  localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [TW-1:0] tick_cnt;
  logic [2:0]    digit_idx;
  logic          frame_boundary;

  logic          pend_full;
  logic [31:0]   pend_value;
  logic [7:0]    pend_en_mask;
  logic [7:0]    pend_dp_mask;
  logic          pend_lzb;

  logic [31:0]   act_value;
  logic [7:0]    act_en_mask;
  logic [7:0]    act_dp_mask;
  logic          act_lzb;

  logic [7:0]    shown_mask;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_seg;
  logic          xfer;

  assign frame_boundary = (tick_cnt == TICK_LAST) && (digit_idx == DIGIT_LAST);
  assign upd_ready      = ~pend_full;
  assign xfer           = upd_valid & ~pend_full;

  // Slot timing: tick counter wraps every slot and advances the digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      digit_idx <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      tick_cnt  <= tick_cnt + TW'(1);
    end
  end

  // Pending/active registers: capture on transfer, promote at frame boundary.
  // A capture in the boundary cycle itself waits for the next boundary,
  // because the pending register was still empty when the boundary hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full    <= 1'b0;
      pend_value   <= '0;
      pend_en_mask <= '0;
      pend_dp_mask <= '0;
      pend_lzb     <= 1'b0;
      act_value    <= '0;
      act_en_mask  <= '0;
      act_dp_mask  <= '0;
      act_lzb      <= 1'b0;
    end else if (xfer) begin
      pend_full    <= 1'b1;
      pend_value   <= upd_value;
      pend_en_mask <= upd_en_mask;
      pend_dp_mask <= upd_dp_mask;
      pend_lzb     <= upd_lzb;
    end else if (frame_boundary && pend_full) begin
      pend_full    <= 1'b0;
      act_value    <= pend_value;
      act_en_mask  <= pend_en_mask;
      act_dp_mask  <= pend_dp_mask;
      act_lzb      <= pend_lzb;
    end
  end

  // Which digits are lit: enable mask minus leading-zero blanking.
  // Scanning from the top nibble down, zero_above stays set while every
  // nibble seen so far (including this one) is zero. Digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    shown_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above    = zero_above & (act_value[4*i +: 4] == 4'h0);
      shown_mask[i] = act_en_mask[i] & ~(act_lzb & zero_above & (i != 0));
    end
  end

  assign cur_nibble = act_value[{digit_idx, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Registered display outputs: blank gap first, then the lit digit if shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp        <= SEG_BLANK;
      dp          <= 1'b1;
      en          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_boundary;
      if ((tick_cnt < TICK_BLANK) || !shown_mask[digit_idx]) begin
        disp <= SEG_BLANK;
        dp   <= 1'b1;
        en   <= AN_OFF;
      end else begin
        disp <= cur_seg;
        dp   <= ~act_dp_mask[digit_idx];
        en   <= ~(8'd1 << digit_idx);
      end
    end
  end

endmodule
